// File: rtl/aligner_out_buffer.sv
// Output buffer behind the aligner: FWFT FIFO drained as an AXI-Stream master,
// with aligner write-enable / upstream hold generation and frame statistics.
module aligner_out_buffer #(
    parameter int DATA_WIDTH   = 256,
    parameter int DEPTH        = 8,
    parameter int AFULL_MARGIN = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [2:0]            flags_in,
    output logic                  wrt_en_out,
    output logic                  hold_upstream,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic [CNT_WIDTH-1:0]  frame_count,
    output logic [CNT_WIDTH-1:0]  last_frame_beats,
    output logic                  overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_LVL  = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] AFULL_LVL = (PTR_W+1)'(DEPTH - AFULL_MARGIN);

    logic [DATA_WIDTH:0]  mem_q [DEPTH];
    logic [DATA_WIDTH:0]  mem_d [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]       count_q, count_d;
    logic                 wrt_en_q, wrt_en_d;
    logic                 overflow_q, overflow_d;
    logic [CNT_WIDTH-1:0] beat_q, beat_d, lfb_q, lfb_d, frame_q, frame_d;
    logic [CNT_WIDTH-1:0] beat_inc;
    logic [DATA_WIDTH:0]  head;
    logic                 in_valid, in_last, full, empty, push, pop;

    assign in_valid = flags_in[2];
    assign in_last  = flags_in[0];
    assign full     = (count_q == FULL_LVL);
    assign empty    = (count_q == '0);
    assign head     = mem_q[rd_ptr_q];

    assign m_axis_tvalid    = !empty;
    assign m_axis_tdata     = head[DATA_WIDTH-1:0];
    assign m_axis_tlast     = head[DATA_WIDTH] & !empty;
    assign pop              = m_axis_tvalid & m_axis_tready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push             = in_valid & (!full | pop);
    assign wrt_en_out       = wrt_en_q;
    assign hold_upstream    = !wrt_en_q | flags_in[1];
    assign overflow         = overflow_q;
    assign frame_count      = frame_q;
    assign last_frame_beats = lfb_q;
    assign beat_inc         = (beat_q == '1) ? beat_q : beat_q + 1'b1;

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        beat_d     = beat_q;
        lfb_d      = lfb_q;
        frame_d    = frame_q;
        overflow_d = overflow_q | (in_valid & full & !pop);
        if (push) begin
            mem_d[wr_ptr_q] = {in_last, data_in};
            wr_ptr_d        = wr_ptr_q + 1'b1;
            if (in_last) begin
                lfb_d  = beat_inc;
                beat_d = '0;
            end else begin
                beat_d = beat_inc;
            end
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            if (m_axis_tlast) frame_d = frame_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // Registered, so the margin absorbs the aligner's one-cycle reaction.
        wrt_en_d = (count_d <= AFULL_LVL);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wrt_en_q   <= 1'b1;
            overflow_q <= 1'b0;
            beat_q     <= '0;
            lfb_q      <= '0;
            frame_q    <= '0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            wrt_en_q   <= wrt_en_d;
            overflow_q <= overflow_d;
            beat_q     <= beat_d;
            lfb_q      <= lfb_d;
            frame_q    <= frame_d;
        end
    end

endmodule
